// File: rtl/config_ctrl_ad.sv
// config_ctrl_ad: front-panel button conditioner and field-select / up-down step controller
// Ports: clk; reset (async, active-low); btn_cfg/btn_up/btn_down/btn_left/btn_right raw buttons;
//        en_count selected field (0 none, 1..NUM_FIELDS); enUP/enDOWN one-cycle step pulses;
//        cfg_active high while in CONFIG; cfg_done one-cycle pulse on every CONFIG exit.
module config_ctrl_ad #(
  parameter int DEB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY   = 50000000,
  parameter int REPEAT_PERIOD  = 10000000,
  parameter int TIMEOUT_CYCLES = 1000000000,
  parameter int NUM_FIELDS     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_cfg,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       cfg_active,
  output logic       cfg_done
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] NF = 4'(NUM_FIELDS);
  typedef enum logic {IDLE, CONFIG} state_t;
  typedef enum logic [1:0] {REP_NONE, REP_UP, REP_DN} rep_t;
  logic [4:0] raw, sync0_q, sync1_q, stable_q, stable_d, ev_q, ev_d;
  logic [DW-1:0] deb_q [5];
  logic [DW-1:0] deb_d [5];
  state_t state_q, state_d;
  rep_t rep_q, rep_d;
  logic [3:0] en_q, en_d;
  logic up_q, up_d, dn_q, dn_d, done_q, done_d, first_q, first_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic ev_cfg, ev_up, ev_dn, ev_l, ev_r, st_up, st_dn;
  assign raw = {btn_right, btn_left, btn_down, btn_up, btn_cfg};
  assign {ev_r, ev_l, ev_dn, ev_up, ev_cfg} = ev_q;
  assign st_up = stable_q[1];
  assign st_dn = stable_q[2];
  // The press pulse is registered on the same edge the stable value flips, keeping
  // the raw-edge-to-output latency at DEB_CYCLES+3.
  always_comb begin
    stable_d = stable_q;
    ev_d = '0;
    for (int i = 0; i < 5; i++) begin
      deb_d[i] = '0;
      if (sync1_q[i] != stable_q[i]) begin
        deb_d[i] = deb_q[i] + 1'b1;
        if (deb_d[i] == DW'(DEB_CYCLES)) begin
          deb_d[i] = '0;
          stable_d[i] = ~stable_q[i];
        end
      end
      ev_d[i] = stable_d[i] & ~stable_q[i];
    end
  end
  always_comb begin
    state_d = state_q;
    en_d = en_q;
    up_d = 1'b0;
    dn_d = 1'b0;
    done_d = 1'b0;
    tmo_d = '0;
    rep_d = rep_q;
    rcnt_d = rcnt_q;
    first_d = first_q;
    if (state_q == IDLE) begin
      rep_d = REP_NONE;
      rcnt_d = '0;
      first_d = 1'b0;
      en_d = '0;
      if (ev_cfg) begin
        state_d = CONFIG;
        en_d = 4'd1;
      end
    end else begin
      tmo_d = (|ev_q || st_up || st_dn) ? '0 : tmo_q + 1'b1;
      if (ev_cfg || tmo_d == TW'(TIMEOUT_CYCLES)) begin
        state_d = IDLE;
        en_d = '0;
        done_d = 1'b1;
        tmo_d = '0;
        rep_d = REP_NONE;
        rcnt_d = '0;
        first_d = 1'b0;
      end else if (ev_l ^ ev_r) begin
        // A field change swallows any coincident up/down and drops a running repeat.
        en_d = ev_r ? (en_q == NF ? 4'd1 : en_q + 4'd1) : (en_q == 4'd1 ? NF : en_q - 4'd1);
        rep_d = REP_NONE;
        rcnt_d = '0;
      end else if (ev_up && !st_dn) begin
        up_d = 1'b1;
        rep_d = REP_UP;
        rcnt_d = '0;
        first_d = 1'b1;
      end else if (ev_dn && !st_up) begin
        dn_d = 1'b1;
        rep_d = REP_DN;
        rcnt_d = '0;
        first_d = 1'b1;
      end else if (rep_q != REP_NONE) begin
        // Releasing the held button or pressing the opposite one disarms until a new press.
        if (rep_q == REP_UP ? (!st_up || st_dn) : (!st_dn || st_up)) begin
          rep_d = REP_NONE;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_d == (first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD))) begin
            rcnt_d = '0;
            first_d = 1'b0;
            up_d = rep_q == REP_UP;
            dn_d = rep_q == REP_DN;
          end
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      stable_q <= '0;
      ev_q <= '0;
      for (int i = 0; i < 5; i++) deb_q[i] <= '0;
      state_q <= IDLE;
      rep_q <= REP_NONE;
      en_q <= '0;
      up_q <= 1'b0;
      dn_q <= 1'b0;
      done_q <= 1'b0;
      first_q <= 1'b0;
      rcnt_q <= '0;
      tmo_q <= '0;
    end else begin
      sync0_q <= raw;
      sync1_q <= sync0_q;
      stable_q <= stable_d;
      ev_q <= ev_d;
      for (int i = 0; i < 5; i++) deb_q[i] <= deb_d[i];
      state_q <= state_d;
      rep_q <= rep_d;
      en_q <= en_d;
      up_q <= up_d;
      dn_q <= dn_d;
      done_q <= done_d;
      first_q <= first_d;
      rcnt_q <= rcnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign en_count = en_q;
  assign enUP = up_q;
  assign enDOWN = dn_q;
  assign cfg_active = state_q == CONFIG;
  assign cfg_done = done_q;
endmodule
